// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional MDU_EARLY_OUT_EN: trivial/special operations complete in one cycle.
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ok,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opb, dvd, res_d, result_q;
  logic [2:0]        f3_q;
  logic              w_q, neg_q, neg_r, div0_q, ovf_q;

  function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Operand preparation at accept
  logic [2:0]      f3;
  logic            w, a_sgn, b_sgn, a_neg, b_neg, div0_p, ovf_p, accept;
  logic [XLEN-1:0] a_x, b_x, a_mag, b_mag;

  always_comb begin
    f3     = op[2:0];
    w      = op[3];
    a_x    = w ? {{(XLEN-32){a[31] & ~op[0]}}, a[31:0]} : a;
    b_x    = w ? {{(XLEN-32){b[31] & ~op[0]}}, b[31:0]} : b;
    a_sgn  = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
    b_sgn  = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
    a_neg  = a_sgn & a_x[XLEN-1];
    b_neg  = b_sgn & b_x[XLEN-1];
    a_mag  = a_neg ? -a_x : a_x;
    b_mag  = b_neg ? -b_x : b_x;
    div0_p = f3[2] && (b_x == '0);
    ovf_p  = ((f3 == 3'd4) || (f3 == 3'd6)) &&
             (w ? ((a_x[31:0] == 32'h8000_0000) && (b_x[31:0] == 32'hFFFF_FFFF))
                : ((a_x == {1'b1, {(XLEN-1){1'b0}}}) && (b_x == '1)));
    accept = valid && !flush;
  end

`ifdef MDU_EARLY_OUT_EN
  logic            early_p;
  logic [XLEN-1:0] early_res;
  always_comb begin
    early_p = div0_p || ovf_p ||
              (!f3[2] && ((a_x == '0) || (b_x == '0))) ||
              (f3[2] && (a_x == '0));
    if (div0_p)     early_res = wext(w, op[1] ? a_x : '1);
    else if (ovf_p) early_res = wext(w, op[1] ? '0 : a_x);
    else            early_res = '0;
  end
`endif

  // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
  logic [XLEN:0]     msum, dsh;
  logic              dge;
  logic [XLEN-1:0]   dsub, qv, rv, raw, fin;
  logic [2*XLEN-1:0] acc_nx, prod;

  always_comb begin
    msum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    dsh    = acc[2*XLEN-1:XLEN-1];
    dge    = dsh >= {1'b0, opb};
    dsub   = dsh[XLEN-1:0] - opb;
    acc_nx = f3_q[2] ? {dge ? dsub : dsh[XLEN-1:0], acc[XLEN-2:0], dge}
                     : {msum, acc[XLEN-1:1]};
    prod   = neg_q ? -acc_nx : acc_nx;
    if (div0_q)     qv = '1;
    else if (ovf_q) qv = dvd;
    else            qv = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    if (div0_q)     rv = dvd;
    else if (ovf_q) rv = '0;
    else            rv = neg_r ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    if (f3_q[2])              raw = f3_q[1] ? rv : qv;
    else if (f3_q[1:0] == 2'd0) raw = prod[XLEN-1:0];
    else                      raw = prod[2*XLEN-1:XLEN];
    fin = wext(w_q, raw);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
`ifdef MDU_EARLY_OUT_EN
        state_nx = early_p ? DONE : BUSY;
`else
        state_nx = BUSY;
`endif
      end
      BUSY: if (flush) state_nx = IDLE;
            else if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ok     = (state == DONE) && !flush;
    busy   = (state != IDLE);
    result = ok ? res_d : result_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      dvd      <= '0;
      res_d    <= '0;
      result_q <= '0;
      f3_q     <= '0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc    <= {{XLEN{1'b0}}, a_mag};
          opb    <= b_mag;
          dvd    <= a_x;
          f3_q   <= f3;
          w_q    <= w;
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          div0_q <= div0_p;
          ovf_q  <= ovf_p;
          cnt    <= '0;
`ifdef MDU_EARLY_OUT_EN
          if (early_p) res_d <= early_res;
`endif
        end
        BUSY: if (!flush) begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) res_d <= fin;
        end
        DONE: if (!flush) result_q <= res_d;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV64M multiply/divide unit: the responder to the execute stage's multiply request; produces the `mult_ok` completion seen by the hazard unit.
- Execute presents operands and holds `valid` while the hazard unit stalls the pipeline.
- The unit computes over a fixed number of radix-2 iterations, then pulses `ok` for one cycle with the result.
- Covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms MULW/DIVW/DIVUW/REMW/REMUW.

Parameters:
- XLEN, 64, operand/result width. Iteration count equals XLEN; counter width is clog2(XLEN)+1.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  request from execute; held high with stable op/a/b until ok
- op  in  4  op[2:0] = RV funct3 (0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU); op[3] = W form
- a  in  XLEN  rs1 value
- b  in  XLEN  rs2 value
- flush  in  1  execute-stage flush; aborts the operation in progress
- ok  out  1  one-cycle completion pulse (drives mult_ok)
- result  out  XLEN  valid while ok=1; held until the next accept
- busy  out  1  high in BUSY or DONE

Behaviour:
- Clock and reset: one clock (`clk`); reset is asynchronous and active-low (`resetn`).
- On reset, including mid-operation: state=IDLE, ok=0, busy=0, result=0, counter=0, internal registers=0.
- FSM states IDLE, BUSY, DONE.
  - IDLE: if valid && !flush, latch op and prepared operands, counter=0, go to BUSY. Otherwise stay.
  - BUSY: perform one iteration per cycle and increment the counter. After the XLEN-th iteration, register the final result and go to DONE.
  - DONE: ok=1 for exactly this cycle, then go to IDLE unconditionally. The pipeline advances on this same edge, so there is no retrigger on a stale valid.
  - flush in BUSY or DONE: go to IDLE next edge; ok is suppressed in that cycle; result is unchanged.
- Latency: valid first high in cycle 0 gives ok=1 in cycle XLEN+1 (cycle 65). Back-to-back requests: the next accept can happen in cycle XLEN+2 at the earliest.
- a/b/op changes during BUSY are ignored; only the values latched at accept are used.
- Operand preparation:
  - W forms: DIVW/REMW/MULW sign-extend a[31:0] and b[31:0]; DIVUW/REMUW zero-extend them.
  - Signedness: a is signed for MULH, MULHSU, DIV, REM and their W forms. b is signed for MULH, DIV, REM.
  - Magnitudes are formed from the operand values; the result sign is recorded at accept.
- Multiply:
  - Shift-add over magnitudes into a 2*XLEN accumulator. Negate the full product when the recorded sign is negative.
  - MUL/MULW take the low XLEN bits; MULH/MULHSU/MULHU take the high XLEN bits.
- Divide:
  - Restoring division over magnitudes, one quotient bit per cycle.
  - Quotient is negated if the operand signs differ (signed ops only). Remainder takes the sign of the dividend.
- RV special cases, with the result fixed at DONE:
  - divide by zero: quotient = all ones; remainder = dividend (after W extension).
  - signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- W forms: result = sign-extension of the low 32 bits of the 64-bit computation.
- valid && flush in the same IDLE cycle: no accept.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- When defined: at accept, the following go straight to DONE with the final result, so ok=1 in cycle 1:
  - divide by zero;
  - signed overflow;
  - multiply with either operand zero (result 0);
  - divide with dividend zero (quotient 0, remainder 0).
- When undefined: every operation has the fixed latency XLEN+1. The special-case values are still produced, but only at DONE.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> ok exactly in cycle 65, result=0xFFFF_FFFF_FFFF_FFEB; ok low in cycles 0-64 and 66.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE; MULHSU a=-1, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF.
- DIV a=-7, b=2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM with same operands -> -1. DIVU a=100, b=0 -> 0xFFFF_FFFF_FFFF_FFFF; REMU -> 100.
- DIV a=0x8000_0000_0000_0000, b=-1 -> result 0x8000_0000_0000_0000; REM -> 0. DIVW a=0x8000_0000, b=-1 -> result 0xFFFF_FFFF_8000_0000. With MDU_EARLY_OUT_EN defined, ok occurs in cycle 1.
- Mid-operation disturbances:
  - Assert flush in cycle 30 -> no ok; a new valid in cycle 32 is accepted and completes in cycle 97.
  - Deassert resetn in cycle 20 -> ok=0, busy=0, result=0 immediately (asynchronous reset).
- Back-to-back: valid held through completion with op changed to MULW a=0x1_0000_0003, b=5 -> first ok in cycle 65, second accepted in cycle 66, ok in cycle 131 with result=0xF.
